apb_reg_slave: RTL
==================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, PWDATA/PRDATA width (8, 16 or 32).
REQ-002 SHALL have parameter ADDR_W, default 32, PADDR width.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count (1..256).
REQ-004 SHALL have parameter WAIT_STATES, default 0, ACCESS cycles with PREADY low before completion (0..15).
REQ-005 SHALL have parameter RO_MASK, default all zero, NUM_REGS bits; bit i=1 makes register i read-only.
REQ-006 SHALL have parameter RESET_VAL, default 0, DATA_W reset value of every register.
REQ-007 SHALL have port PCLK, input, 1, single clock; all state updates on its rising edge.
REQ-008 SHALL have port PRESETn, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have port PSEL, input, 1, slave select.
REQ-010 SHALL have port PENABLE, input, 1, access phase.
REQ-011 SHALL have port PWRITE, input, 1, 1=write, 0=read.
REQ-012 SHALL have port PADDR, input, ADDR_W, byte address.
REQ-013 SHALL have port PWDATA, input, DATA_W, write data.
REQ-014 SHALL have port PSTRB, input, DATA_W/8, write byte lanes.
REQ-015 SHALL have port PRDATA, output, DATA_W, read data.
REQ-016 SHALL have port PREADY, output, 1, transfer completion.
REQ-017 SHALL have port PSLVERR, output, 1, error; valid only while PREADY=1.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE to SETUP on PSEL=1 with PENABLE=0.
- SETUP to ACCESS unconditionally.
- ACCESS to IDLE in the cycle PREADY=1.
- ACCESS to SETUP instead if the master starts a back-to-back SETUP.
REQ-019 SHALL clear the wait counter on SETUP entry and increment it every ACCESS cycle with PREADY=0.
REQ-020 SHALL drive PREADY = PSEL & PENABLE & (state==ACCESS) & (count==WAIT_STATES); with WAIT_STATES=0, PREADY is high in the first ACCESS cycle.
REQ-021 SHALL decode index = PADDR[ADDR_W-1:log2(DATA_W/8)].
REQ-022 SHALL flag an error when any of the following holds:
- index >= NUM_REGS;
- PADDR is not aligned to DATA_W/8;
- a write targets a register with its RO_MASK bit set.
REQ-023 SHALL commit a write only on the rising edge where PREADY=1, PWRITE=1 and no error, updating only the byte lanes whose PSTRB bit is 1.
REQ-024 SHALL drive PRDATA = register[index] while PREADY=1, PWRITE=0 and no error; otherwise PRDATA SHALL be 0.
REQ-025 SHALL drive PSLVERR = PREADY & error, and 0 at all other times.
REQ-026 SHALL leave registers unchanged on an errored write.
REQ-027 SHALL drop a transfer without side effects if PSEL deasserts mid-ACCESS, and return to IDLE.
REQ-028 SHALL treat PENABLE=1 seen in IDLE (protocol violation) as no access: PREADY=0 and no write.
REQ-029 SHALL sample PADDR, PWRITE, PWDATA and PSTRB only in the completion cycle (APB holds them stable).

Reset
REQ-030 SHALL, on PRESETn=0 and independent of PCLK:
- force state to IDLE and the counter to 0;
- load every register with RESET_VAL;
- drive PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-031 SHALL abort any in-flight transfer on reset with no register update; reset deassertion SHALL take effect at the next PCLK edge.

Structure
REQ-032 SHALL place the state enum (IDLE/SETUP/ACCESS) and the max-WAIT_STATES constant in the shared package apb_pkg.
REQ-033 SHALL be a single module with no sub-module; the register array and FSM are local.

Verification
REQ-034 Write 0xA5A5A5A5 to addr 0x4 (WAIT_STATES=0), then read 0x4 -> PREADY high in the first ACCESS cycle; PRDATA=0xA5A5A5A5; PSLVERR=0.
REQ-035 WAIT_STATES=3, read addr 0x0 after reset -> exactly 3 ACCESS cycles with PREADY=0, then PREADY=1 with PRDATA=RESET_VAL.
REQ-036 Write 0xFFFFFFFF with PSTRB=4'b0101 to a register holding 0 -> readback 0x00FF00FF.
REQ-037 Access addr 0x20 (NUM_REGS=8), then addr 0x2 (misaligned) -> PSLVERR=1 with PREADY; no register changes; PRDATA=0.
REQ-038 RO_MASK bit 1 set, write 0x1234 to addr 0x4 -> PSLVERR=1; readback shows the prior value.
REQ-039 Assert PRESETn=0 mid-ACCESS of a write with WAIT_STATES=2 -> outputs 0 immediately; the target register holds RESET_VAL; the next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus phase encoding and wait-state limits.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_MAX_WAIT_STATES = 15;
    localparam int APB_CNT_W           = $clog2(APB_MAX_WAIT_STATES + 1);

endpackage

// File: rtl/apb_reg_slave.sv
// APB register-file slave: NUM_REGS word registers with byte strobes,
// per-register read-only masking, programmable wait states and error response.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int                    LANES      = DATA_W / 8;
    localparam int                    OFF_W      = $clog2(LANES);
    localparam int                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0]     NUM_REGS_A = ADDR_W'(NUM_REGS);
    localparam logic [APB_CNT_W-1:0]  WAIT_LAST  = APB_CNT_W'(WAIT_STATES);

    apb_state_e           r_state;
    apb_state_e           w_state;
    apb_state_e           w_state_next;
    logic [APB_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];

    logic [ADDR_W-1:0]    w_index;
    logic [IDX_W-1:0]     w_reg_sel;
    logic                 w_in_range;
    logic                 w_misaligned;
    logic                 w_read_only;
    logic                 w_err;
    logic                 w_pready;
    logic                 w_wr_commit;

    // ------------------------------------------------------------------
    // Address decode and error classification
    // ------------------------------------------------------------------
    assign w_index    = PADDR >> OFF_W;
    assign w_reg_sel  = w_index[IDX_W-1:0];
    assign w_in_range = (w_index < NUM_REGS_A);

    generate
        if (OFF_W == 0) begin : g_byte_bus
            assign w_misaligned = 1'b0;
        end else begin : g_word_bus
            assign w_misaligned = |PADDR[OFF_W-1:0];
        end
    endgenerate

    assign w_read_only = w_in_range & RO_MASK[w_reg_sel];
    assign w_err       = ~w_in_range | w_misaligned | (PWRITE & w_read_only);

    // ------------------------------------------------------------------
    // Bus phase FSM. SETUP is recognised from the bus in the same cycle,
    // so the register only has to remember that an ACCESS phase is due;
    // this is what lets PREADY rise in the first ACCESS cycle.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state      = ST_IDLE;
        w_pready     = 1'b0;
        w_state_next = ST_IDLE;

        if (PSEL && !PENABLE) begin
            w_state = ST_SETUP;
        end else if (PSEL && PENABLE && (r_state == ST_ACCESS)) begin
            w_state = ST_ACCESS;
        end

        w_pready = PSEL && PENABLE && (w_state == ST_ACCESS) && (r_count == WAIT_LAST);

        case (w_state)
            ST_SETUP:  w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = w_pready ? ST_IDLE : ST_ACCESS;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_count <= '0;
        end else if (w_state == ST_SETUP) begin
            r_count <= '0;
        end else if ((w_state == ST_ACCESS) && !w_pready) begin
            r_count <= r_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    assign w_wr_commit = w_pready & PWRITE & ~w_err;

    // NOTE: the register array is reset on purpose -- software relies on RESET_VAL, so it cannot map to an unreset RAM.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_wr_commit) begin
            for (int b = 0; b < LANES; b++) begin
                if (PSTRB[b]) begin
                    r_regs[w_reg_sel][b*8 +: 8] <= PWDATA[b*8 +: 8];
                end
            end
        end
    end

    // Outputs are purely combinational and gated by PREADY, so reset zeroes them at once.
    assign PREADY  = w_pready;
    assign PSLVERR = w_pready & w_err;
    assign PRDATA  = (w_pready & ~PWRITE & ~w_err) ? r_regs[w_reg_sel] : '0;

endmodule
